// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async FIFO family.
// Optional feature macro used by the read-side block: RPTR_UFLOW_EN.
package fifo_pkg;

    localparam int unsigned ADDRSIZE_DEF = 4;
    localparam int unsigned UFLOW_CNT_W  = 8;
    localparam int unsigned GRAY_MAX_W   = 32;

    // Binary to reflected Gray; callers zero-extend into and truncate out of GRAY_MAX_W.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray to binary conversion: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin_c
);

    // Suffix XOR reduction per bit keeps the net graph acyclic.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_c[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty / almost-empty flags, fill level and read-accept strobe.
// Optional macro RPTR_UFLOW_EN adds a sticky underflow flag and a saturating
// rejected-read counter.
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rwptr2,
    input  logic [ADDRSIZE:0]   rae_th,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
`ifdef RPTR_UFLOW_EN
    output logic                   ruflow,
    output logic [UFLOW_CNT_W-1:0] ruflow_cnt,
`endif
    output logic                rack
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin_q,    rbin_d;
    logic [PW-1:0] rptr_q,    rptr_d;
    logic          rempty_q,  rempty_d;
    logic          raempty_q, raempty_d;
    logic [PW-1:0] rlevel_q,  rlevel_d;
    logic          rack_q,    rack_d;

    logic          acc_c;
    logic [PW-1:0] rwbin_c;

`ifdef RPTR_UFLOW_EN
    logic                   ruflow_q,     ruflow_d;
    logic [UFLOW_CNT_W-1:0] ruflow_cnt_q, ruflow_cnt_d;
`endif

    gray2bin #(.W(PW)) u_wptr_g2b (
        .gray  (rwptr2),
        .bin_c (rwbin_c)
    );

    // Reads are only accepted while the registered empty flag is low.
    assign acc_c = rinc & ~rempty_q;

    // Next pointer pair, level and flags, all from the post-accept pointer.
    always_comb begin
        rbin_d    = rbin_q + PW'(acc_c);
        rptr_d    = PW'(bin2gray(GRAY_MAX_W'(rbin_d)));
        rlevel_d  = rwbin_c - rbin_d;
        rempty_d  = (rptr_d == rwptr2);
        raempty_d = (rlevel_d <= rae_th);
        rack_d    = acc_c;
    end

`ifdef RPTR_UFLOW_EN
    // Sticky underflow and saturating count of reads rejected while empty.
    always_comb begin
        ruflow_d     = ruflow_q;
        ruflow_cnt_d = ruflow_cnt_q;
        if (rinc && rempty_q) begin
            ruflow_d = 1'b1;
            if (ruflow_cnt_q != {UFLOW_CNT_W{1'b1}}) begin
                ruflow_cnt_d = ruflow_cnt_q + UFLOW_CNT_W'(1);
            end
        end
    end

    // Underflow state registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            ruflow_q     <= 1'b0;
            ruflow_cnt_q <= '0;
        end else begin
            ruflow_q     <= ruflow_d;
            ruflow_cnt_q <= ruflow_cnt_d;
        end
    end

    assign ruflow     = ruflow_q;
    assign ruflow_cnt = ruflow_cnt_q;
`endif

    // Pointer, flag and level registers; reset wins over any pending read.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rlevel_q  <= '0;
            rack_q    <= 1'b0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            rlevel_q  <= rlevel_d;
            rack_q    <= rack_d;
        end
    end

    assign raddr   = rbin_q[ADDRSIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rlevel  = rlevel_q;
    assign rack    = rack_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Self-checking bench for rptr_empty_lvl (ADDRSIZE=4) with a queue scoreboard.
module tb_rptr_empty_lvl;

    logic       rclk;
    logic       rrst;
    logic       rinc;
    logic [4:0] rwptr2;
    logic [4:0] rae_th;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       rack;
`ifdef RPTR_UFLOW_EN
    logic       ruflow;
    logic [7:0] ruflow_cnt;
`endif

    rptr_empty_lvl #(.ADDRSIZE(4)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rinc    (rinc),
        .rwptr2  (rwptr2),
        .rae_th  (rae_th),
        .raddr   (raddr),
        .rptr    (rptr),
        .rempty  (rempty),
        .raempty (raempty),
        .rlevel  (rlevel),
`ifdef RPTR_UFLOW_EN
        .ruflow     (ruflow),
        .ruflow_cnt (ruflow_cnt),
`endif
        .rack    (rack)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        int ptr;
        int addr;
        int empty;
        int aempty;
        int level;
        int ack;
        int uf;
        int ufc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: read count, empty flag, underflow state.
    int m_rbin  = 0;
    int m_empty = 1;
    int m_uf    = 0;
    int m_ufc   = 0;
    int wcnt    = 0;

    function automatic logic [4:0] g5(input int v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare after the edge.
    task automatic step(input logic rst_v, input logic inc_v, input int w);
        exp_t e;
        int   acc;
        int   lvl;
        rrst   = rst_v;
        rinc   = inc_v;
        wcnt   = w & 31;
        rwptr2 = g5(wcnt);
        if (rst_v) begin
            m_rbin = 0; m_empty = 1; m_uf = 0; m_ufc = 0;
            e = '{ptr: 0, addr: 0, empty: 1, aempty: 1, level: 0, ack: 0, uf: 0, ufc: 0};
        end else begin
            acc = (inc_v && !m_empty) ? 1 : 0;
            if (inc_v && m_empty) begin
                m_uf = 1;
                if (m_ufc < 255) m_ufc++;
            end
            m_rbin  = (m_rbin + acc) & 31;
            lvl     = (wcnt - m_rbin) & 31;
            m_empty = (lvl == 0) ? 1 : 0;
            e.ptr    = int'(g5(m_rbin));
            e.addr   = m_rbin & 15;
            e.empty  = m_empty;
            e.aempty = (lvl <= int'(rae_th)) ? 1 : 0;
            e.level  = lvl;
            e.ack    = acc;
            e.uf     = m_uf;
            e.ufc    = m_ufc;
        end
        sb.push_back(e);
        @(posedge rclk);
        #1;
        e = sb.pop_front();
        chk("rptr",    32'(rptr),    32'(e.ptr));
        chk("raddr",   32'(raddr),   32'(e.addr));
        chk("rempty",  32'(rempty),  32'(e.empty));
        chk("raempty", 32'(raempty), 32'(e.aempty));
        chk("rlevel",  32'(rlevel),  32'(e.level));
        chk("rack",    32'(rack),    32'(e.ack));
`ifdef RPTR_UFLOW_EN
        chk("ruflow",     32'(ruflow),     32'(e.uf));
        chk("ruflow_cnt", 32'(ruflow_cnt), 32'(e.ufc));
`endif
    endtask

    initial begin
        int acks;
        int w;
        logic [4:0] prev_ptr;
        logic [3:0] prev_addr;
        int addr_wrap;
        int bin_wrap;
        logic wr;
        logic rd;

        rae_th = 5'd4;

        // Reset held two edges with a pending read and a non-zero write pointer.
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 2);
        chk("rst_rptr",  32'(rptr),  32'd0);
        chk("rst_empty", 32'(rempty), 32'd1);

        // Fill three words one Gray step at a time, read ignored while empty.
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 2);
        step(1'b0, 1'b0, 3);
        chk("fill_level", 32'(rlevel), 32'd3);

        // Drain with five read requests: exactly three accepted.
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 3);
            acks += int'(rack);
        end
        chk("drain_acks",  32'(acks),   32'd3);
        chk("drain_raddr", 32'(raddr),  32'd3);
        chk("drain_empty", 32'(rempty), 32'd1);

        // Almost-empty threshold crossing at 2.
        rae_th = 5'd2;
        step(1'b0, 1'b0, 7);
        chk("ae_lvl4", 32'(raempty), 32'd0);
        step(1'b0, 1'b1, 7);
        chk("ae_lvl3", 32'(raempty), 32'd0);
        step(1'b0, 1'b1, 7);
        chk("ae_lvl2_level", 32'(rlevel),  32'd2);
        chk("ae_lvl2",       32'(raempty), 32'd1);

        // Threshold zero: almost-empty follows empty.
        rae_th = 5'd0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i != 0), 7);
            chk("ae_th0_track", 32'(raempty), 32'(rempty));
        end

        // Long mixed traffic across pointer wrap with level kept low.
        w = 7;
        addr_wrap = 0;
        bin_wrap  = 0;
        for (int i = 0; i < 80; i++) begin
            wr = (int'(rlevel) < 3) && (i % 3 != 0);
            rd = (i % 5 != 4);
            if (wr) w++;
            prev_ptr  = rptr;
            prev_addr = raddr;
            step(1'b0, rd, w);
            chk("wrap_onebit", 32'($countones(rptr ^ prev_ptr)), rack ? 32'd1 : 32'd0);
            if (rack && prev_addr == 4'd15 && raddr == 4'd0) addr_wrap = 1;
            if (rack && prev_ptr == g5(31) && rptr == 5'd0) bin_wrap = 1;
        end
        chk("wrap_addr", 32'(addr_wrap), 32'd1);
        chk("wrap_bin",  32'(bin_wrap),  32'd1);

        // Full level, then read with simultaneous write keeps level at 16.
        rae_th = 5'd2;
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 16);
        chk("full_level", 32'(rlevel), 32'd16);
        chk("full_empty", 32'(rempty), 32'd0);
        step(1'b0, 1'b1, 17);
        chk("simul_level", 32'(rlevel), 32'd16);
        chk("simul_ack",   32'(rack),   32'd1);

        // Reset beats a pending read mid-operation.
        step(1'b1, 1'b1, 17);
        chk("rst_prio_level", 32'(rlevel), 32'd0);

        // Many reads while empty: pointer must not move.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 0);
        end
        chk("uflow_rptr", 32'(rptr), 32'd0);
`ifdef RPTR_UFLOW_EN
        chk("uflow_flag", 32'(ruflow),     32'd1);
        chk("uflow_cnt",  32'(ruflow_cnt), 32'd255);
        step(1'b1, 1'b0, 0);
        chk("uflow_clr_flag", 32'(ruflow),     32'd0);
        chk("uflow_clr_cnt",  32'(ruflow_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
